input_debouncer: RTL and testbench
==================================

# input_debouncer

Two-channel input conditioning stage that sits directly upstream of the `andgate` logic block. It takes two raw, asynchronous, possibly bouncing board inputs (switches/buttons), synchronises them into the `clk` domain, debounces each with a stability counter, and drives clean `a`/`b` levels plus single-cycle edge strobes. Its level outputs connect straight to the gate's `a`/`b` inputs.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 50000: consecutive cycles a new level must persist before it is accepted (1 ms at 50 MHz). Legal range is 2 ≤ N < 2**`CNT_WIDTH`.
- `CNT_WIDTH`, default 16: width of each channel's stability counter.

Ports:
- `clk`, in, 1: single system clock, rising-edge.
- `rst_n`, in, 1: reset, **asynchronous, active-low**.
- `raw_a`, in, 1: raw input A. Asynchronous to `clk`.
- `raw_b`, in, 1: raw input B. Asynchronous to `clk`.
- `a`, out, 1: debounced level of A.
- `b`, out, 1: debounced level of B.
- `a_rise`, out, 1: one-cycle pulse when `a` goes 0→1.
- `a_fall`, out, 1: one-cycle pulse when `a` goes 1→0.
- `b_rise`, out, 1: one-cycle pulse when `b` goes 0→1.
- `b_fall`, out, 1: one-cycle pulse when `b` goes 1→0.

## Operation
- The two channels are identical and fully independent. They share no counters or state.
- **Synchroniser:** each channel has a 2-flop chain `s1`→`s2`. The debounce logic uses only `s2`.
- **Per-channel FSM** has two states:
  - **STABLE:** `s2 == out`. Counter is held at 0.
  - **PENDING:** `s2 != out`. Counter increments by 1 every cycle.
  - From PENDING, if `s2` returns to equal `out` before the count completes, go to STABLE, clear the counter, and leave `out` unchanged (the glitch is rejected).
  - From PENDING, on the edge where the counter equals N−1 and `s2 != out` still holds: `out <= s2`, counter <= 0, and assert the matching rise/fall pulse for exactly one cycle. Next state is STABLE.
- **Counter:** unsigned, `CNT_WIDTH` bits. It never wraps, because it is cleared on acceptance or on mismatch loss.
- **Pulses:** registered, and asserted on the same edge that `out` changes. `*_rise` and `*_fall` are never high together.
- **Simultaneous events:** A and B may accept on the same cycle, and both channels' pulses then assert together.
- **Reset values:** on `rst_n` low, all of the following are 0 immediately, independent of `clk`:
  - `s1`, `s2`, counters, FSM state (STABLE);
  - `a`, `b`;
  - all four pulses.
- **Reset mid-PENDING:** the count in progress is discarded. After `rst_n` release, a raw level of 1 is re-qualified from scratch, taking the full latency, and produces a `*_rise` pulse.

## Timing
- Raw level settles before clock edge 0:
  - `s1` captures it at edge 0.
  - `s2` captures it at edge 1.
  - The first PENDING increment happens at edge 2.
  - `out` and the pulse update at edge N+1.
- Total latency is N+2 rising edges, counting edge 0.
- Any raw excursion that holds for fewer than N consecutive cycles at `s2` causes no output change.
- Pulse width is exactly 1 `clk` cycle. Minimum spacing between two pulses on one channel is N cycles.
- `rst_n` assertion is asynchronous. Deassertion is assumed synchronised externally to `clk`.

## Structure
- Shared package/header holds:
  - FSM state encoding: `ST_STABLE` = 1'b0, `ST_PENDING` = 1'b1.
  - Default `DEBOUNCE_CYCLES` constant.
- One sub-module, `debounce_channel`, containing the synchroniser, counter, FSM and edge pulses, with ports `clk`, `rst_n`, `raw`, `level`, `rise`, `fall`. The top instantiates it twice.
- Elaboration-time check rejects `DEBOUNCE_CYCLES` < 2 or ≥ 2**`CNT_WIDTH`.

## Test plan
Conditions for all scenarios: `DEBOUNCE_CYCLES`=4, `CNT_WIDTH`=4, 10 ns clock.
1. **Reset:** hold `rst_n`=0 with `raw_a`=`raw_b`=1 → all six outputs 0 throughout. Release → `a`=`b`=1 after 6 edges, with `a_rise`/`b_rise` high for one cycle on the same edge.
2. **Clean step:** `raw_a` 0→1 before edge 0 and held → `a`=1 and `a_rise`=1 at edge 5 only; `b` and B pulses stay 0. Then `raw_a` 1→0 → `a_fall` pulse 6 edges later.
3. **Bounce rejection:** `raw_a` toggles high 3 cycles, low 1, high 2, low → `a` stays 0 and no pulses.
4. **Bounce then settle:** `raw_b` glitches for 2 cycles, then goes 1 and holds → `b`=1 exactly 6 edges after the final transition, with a single `b_rise`.
5. **Simultaneous:** `raw_a` and `raw_b` rise on the same cycle → `a_rise` and `b_rise` assert on the same edge. Downstream `andgate` output goes 1 that cycle.
6. **Reset mid-PENDING:** `raw_a`=1 for 3 cycles, pulse `rst_n` low for 1 cycle, keep `raw_a`=1 → `a` goes 1 only 6 edges after release, and `a_rise` occurs once.

Source files
------------

// File: rtl/input_debouncer_pkg.sv
// Shared constants and channel FSM encoding for the two-channel input debouncer.
package input_debouncer_pkg;

   localparam int DEBOUNCE_CYCLES_DEF = 50000;
   localparam int CNT_WIDTH_DEF       = 16;

   typedef enum logic {
      ST_STABLE  = 1'b0,
      ST_PENDING = 1'b1
   } state_e;

endpackage

// File: rtl/input_debouncer_debounce_channel.sv
// One debounce channel: 2-flop synchroniser, stability counter, FSM, edge pulses.
module debounce_channel
   import input_debouncer_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int CNT_WIDTH       = CNT_WIDTH_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

   logic                 s1_q, s1_d;
   logic                 s2_q, s2_d;
   logic                 level_q, level_d;
   logic                 rise_q, rise_d;
   logic                 fall_q, fall_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   state_e               state_q, state_d;

   always_comb begin
      s1_d    = raw;
      s2_d    = s1_q;
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      cnt_d   = '0;
      state_d = ST_STABLE;
      unique case (state_q)
         ST_STABLE: begin
            if (s2_q != level_q) begin
               state_d = ST_PENDING;
               cnt_d   = CNT_ONE;
            end
         end
         ST_PENDING: begin
            // A return to the current level drops the count (glitch rejected).
            if (s2_q != level_q) begin
               if (cnt_q == CNT_LAST) begin
                  level_d = s2_q;
                  rise_d  = s2_q;
                  fall_d  = ~s2_q;
               end else begin
                  state_d = ST_PENDING;
                  cnt_d   = cnt_q + CNT_ONE;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         cnt_q   <= '0;
         state_q <= ST_STABLE;
      end else begin
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         cnt_q   <= cnt_d;
         state_q <= state_d;
      end
   end

   assign level = level_q;
   assign rise  = rise_q;
   assign fall  = fall_q;

endmodule

// File: rtl/input_debouncer.sv
// Two independent debounce channels conditioning raw board inputs into a/b levels
// plus one-cycle edge strobes.
module input_debouncer
   import input_debouncer_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int CNT_WIDTH       = CNT_WIDTH_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw_a,
   input  logic raw_b,
   output logic a,
   output logic b,
   output logic a_rise,
   output logic a_fall,
   output logic b_rise,
   output logic b_fall
);

   if ((DEBOUNCE_CYCLES < 2) ||
       (64'(DEBOUNCE_CYCLES) >= (64'd1 << CNT_WIDTH))) begin : g_bad_cfg
      $error("input_debouncer: DEBOUNCE_CYCLES out of range for CNT_WIDTH");
   end

   debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_WIDTH       (CNT_WIDTH)
   ) u_ch_a (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (raw_a),
      .level (a),
      .rise  (a_rise),
      .fall  (a_fall)
   );

   debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_WIDTH       (CNT_WIDTH)
   ) u_ch_b (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (raw_b),
      .level (b),
      .rise  (b_rise),
      .fall  (b_fall)
   );

endmodule

// File: tb/tb_input_debouncer.sv
// Scoreboard bench: windowed reference model predicts outputs every edge,
// a monitor pops and compares one cycle-slot per edge.
module tb_input_debouncer;

   localparam int N = 4;
   localparam int W = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic raw_a = 1'b0;
   logic raw_b = 1'b0;
   logic a, b, a_rise, a_fall, b_rise, b_fall;

   input_debouncer #(
      .DEBOUNCE_CYCLES (N),
      .CNT_WIDTH       (W)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw_a  (raw_a),
      .raw_b  (raw_b),
      .a      (a),
      .b      (b),
      .a_rise (a_rise),
      .a_fall (a_fall),
      .b_rise (b_rise),
      .b_fall (b_fall)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passed = 0;

   logic [5:0] expq[$];
   bit rawh[2][$];
   bit s2h[2][$];
   bit om[2];
   bit er[2];
   bit ef[2];
   bit rin[2];

   function automatic logic [5:0] outs();
      return {a, b, a_rise, a_fall, b_rise, b_fall};
   endfunction

   task automatic check(input string name, input logic [5:0] act,
                        input logic [5:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s got={a,b,ar,af,br,bf}=%b expected=%b at %0t",
                    name, act, exp, $time);
   endtask

   // Model: the synchronised sample seen at an edge is the raw level two edges
   // earlier; a level is accepted once N consecutive seen samples equal it and
   // differ from the current output.
   task automatic model_reset();
      for (int c = 0; c < 2; c++) begin
         rawh[c].delete();
         s2h[c].delete();
         rawh[c].push_back(1'b0);
         rawh[c].push_back(1'b0);
         om[c] = 1'b0;
      end
   endtask

   always @(posedge clk) begin
      if (!rst_n) begin
         model_reset();
         expq.push_back(6'b0);
      end else begin
         rin[0] = raw_a;
         rin[1] = raw_b;
         for (int c = 0; c < 2; c++) begin
            bit s, same;
            rawh[c].push_back(rin[c]);
            s = rawh[c][rawh[c].size() - 3];
            if (rawh[c].size() > 8) void'(rawh[c].pop_front());
            s2h[c].push_back(s);
            if (s2h[c].size() > N) void'(s2h[c].pop_front());
            er[c] = 1'b0;
            ef[c] = 1'b0;
            if (s2h[c].size() == N && s != om[c]) begin
               same = 1'b1;
               foreach (s2h[c][i]) if (s2h[c][i] != s) same = 1'b0;
               if (same) begin
                  om[c] = s;
                  er[c] = s;
                  ef[c] = ~s;
               end
            end
         end
         expq.push_back({om[0], om[1], er[0], ef[0], er[1], ef[1]});
      end
   end

   always @(posedge clk) begin
      #1;
      if (expq.size() == 0) begin
         checks++;
         $display("FAIL scoreboard_underflow got=empty expected=entry");
      end else begin
         check("cycle", outs(), expq.pop_front());
      end
   end

   task automatic drive(input bit va, input bit vb, input int n);
      raw_a = va;
      raw_b = vb;
      repeat (n) @(negedge clk);
   endtask

   task automatic async_reset_pulse();
      rst_n = 1'b0;
      #1;
      check("async_reset", outs(), 6'b0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   int la, lb;

   initial begin
      model_reset();
      raw_a = 1'b1;
      raw_b = 1'b1;
      #2;
      check("reset_t0", outs(), 6'b0);
      repeat (3) @(negedge clk);
      check("reset_held", outs(), 6'b0);
      rst_n = 1'b1;
      drive(1, 1, 10);
      // clean step on A, both directions
      drive(0, 0, 10);
      drive(1, 0, 10);
      drive(0, 0, 10);
      // bounce rejection on A
      drive(1, 0, 3);
      drive(0, 0, 1);
      drive(1, 0, 2);
      drive(0, 0, 10);
      // bounce then settle on B
      drive(0, 1, 2);
      drive(0, 0, 1);
      drive(0, 1, 10);
      // simultaneous rise
      drive(0, 0, 10);
      drive(1, 1, 10);
      async_reset_pulse();
      drive(1, 1, 10);
      // reset mid-pending
      drive(0, 0, 10);
      drive(1, 0, 3);
      async_reset_pulse();
      drive(1, 0, 10);
      // random run lengths around the threshold
      la = 0;
      lb = 0;
      for (int i = 0; i < 600; i++) begin
         if (la == 0) begin
            raw_a = 1'($urandom_range(0, 1));
            la = $urandom_range(1, 7);
         end
         if (lb == 0) begin
            raw_b = 1'($urandom_range(0, 1));
            lb = $urandom_range(1, 7);
         end
         la--;
         lb--;
         if ($urandom_range(0, 149) == 0) async_reset_pulse();
         else @(negedge clk);
      end
      drive(0, 0, 12);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
